div_ctrl: RTL and testbench

Multi-cycle divider sequencer for the execute stage of the 5-stage MIPS pipeline. It accepts a DIV/DIVU operation from E, runs a 32-iteration radix-2 restoring division, and holds the pipeline through `stall`, which drives the hazard unit's `div_stallE` input. On completion it presents quotient and remainder for the HI/LO write path.

---
 rtl/div_ctrl_if.sv | 25 ++
 rtl/div_ctrl.sv | 127 ++++++++++++
 tb/tb_div_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Handshake and operand/result bundle between the execute stage and the divider sequencer.
// master = execute stage issuing DIV/DIVU, slave = div_ctrl.
interface div_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;

   modport master (
      output start, signed_div, a, b, cancel,
      input  stall, done, lo, hi
   );

   modport slave (
      input  start, signed_div, a, b, cancel,
      output stall, done, lo, hi
   );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for the execute stage.
// Holds the pipeline via stall while iterating; presents quotient (lo) and remainder (hi).
module div_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   div_ctrl_if.slave  bus
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic [WIDTH-1:0]  dvd_q, dvd_d;
   logic [WIDTH-1:0]  dsr_q, dsr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              done_q, done_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [WIDTH:0]    rem_sh;
   logic [WIDTH+1:0]  trial;
   logic              q_bit;
   logic [WIDTH-1:0]  rem_nxt, q_nxt;

   assign a_mag = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_mag = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // One extra guard bit so the sign of the trial subtraction is never aliased.
   assign rem_sh  = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = {1'b0, rem_sh} - {2'b00, dsr_q};
   assign q_bit   = ~trial[WIDTH+1];
   assign rem_nxt = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign q_nxt   = {dvd_q[WIDTH-2:0], q_bit};

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      count_d = count_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.b == '0) begin
                  state_d = StDone;
                  lo_d    = '1;
                  hi_d    = bus.a;
                  done_d  = 1'b1;
               end else begin
                  state_d = StBusy;
                  dvd_d   = a_mag;
                  dsr_d   = b_mag;
                  qneg_d  = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  rneg_d  = bus.signed_div & bus.a[WIDTH-1];
                  rem_d   = '0;
                  count_d = '0;
               end
            end
         end
         StBusy: begin
            rem_d   = rem_nxt;
            dvd_d   = q_nxt;
            count_d = count_q + CntW'(1);
            if (count_q == CntW'(WIDTH - 1)) begin
               state_d = StDone;
               done_d  = 1'b1;
               lo_d    = qneg_q ? -q_nxt : q_nxt;
               hi_d    = rneg_q ? -rem_nxt : rem_nxt;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Flush wins over everything: abandon the operation and keep the old results.
      if (bus.cancel) begin
         state_d = StIdle;
         done_d  = 1'b0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rem_q   <= '0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         count_q <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         count_q <= count_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Combinational so the hazard unit can freeze F/D/E in the acceptance cycle.
   assign bus.stall = ((state_q == StIdle && bus.start) || state_q == StBusy) && !bus.cancel;
   assign bus.done  = done_q;
   assign bus.lo    = lo_q;
   assign bus.hi    = hi_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: timing, signed/unsigned results, divide by zero,
// cancel and mid-operation reset.
module tb_div_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   div_ctrl_if #(.WIDTH(32)) bus ();

   div_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next cycle; observations are taken 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from an IDLE cycle; returns cycles to done and the results seen then.
   // Leaves the bench in the IDLE cycle following DONE (or after the bound expires).
   task automatic run_op(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                         output int cyc, output logic [31:0] hi_o, output logic [31:0] lo_o);
      bus.signed_div = sgn;
      bus.a          = av;
      bus.b          = bv;
      bus.start      = 1'b1;
      #1;
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      hi_o      = bus.hi;
      lo_o      = bus.lo;
      bus.start = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got %b want 0", bus.done);
      end
      checks++;
      if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
         errors++;
         $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", bus.hi, bus.lo);
      end
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall: got %b want 0", bus.stall);
      end
      tick();
   endtask

   task automatic test_divu_basic();
      int bad_stall;
      bad_stall = 0;
      bus.signed_div = 1'b0;
      bus.a          = 32'd100;
      bus.b          = 32'd7;
      bus.start      = 1'b1;
      #1;
      for (int c = 0; c <= 32; c++) begin
         if (bus.stall !== 1'b1 || bus.done !== 1'b0) bad_stall++;
         tick();
      end
      checks++;
      if (bad_stall != 0) begin
         errors++;
         $display("FAIL divu_stall_window: %0d bad cycles in 0..32, want 0", bad_stall);
      end
      // cycle 33: DONE with start still held
      checks++;
      if (bus.done !== 1'b1 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL divu_done_cycle33: got done=%b stall=%b want 1/0", bus.done, bus.stall);
      end
      checks++;
      if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
         errors++;
         $display("FAIL divu_100_7: got lo=%h hi=%h want 0000000e/00000002", bus.lo, bus.hi);
      end
      tick();
      bus.start = 1'b0;
      #1;
      checks++;
      if (bus.done !== 1'b0 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL divu_no_retrigger: got done=%b stall=%b want 0/0", bus.done, bus.stall);
      end
      tick();
   endtask

   task automatic test_signed();
      int          cyc;
      logic [31:0] h, l;
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, cyc, h, l);
      checks++;
      if (cyc != 33 || l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_m7_2: got cyc=%0d lo=%h hi=%h want 33/fffffffd/ffffffff", cyc, l, h);
      end
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, cyc, h, l);
      checks++;
      if (cyc != 33 || l !== 32'hFFFF_FFFD || h !== 32'h0000_0001) begin
         errors++;
         $display("FAIL div_7_m2: got cyc=%0d lo=%h hi=%h want 33/fffffffd/00000001", cyc, l, h);
      end
      run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, cyc, h, l);
      checks++;
      if (l !== 32'd14 || h !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL div_m100_m7: got lo=%h hi=%h want 0000000e/fffffffe", l, h);
      end
   endtask

   task automatic test_overflow();
      int          cyc;
      logic [31:0] h, l;
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc, h, l);
      checks++;
      if (l !== 32'h8000_0000 || h !== 32'h0) begin
         errors++;
         $display("FAIL div_overflow: got lo=%h hi=%h want 80000000/00000000", l, h);
      end
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, cyc, h, l);
      checks++;
      if (l !== 32'h0 || h !== 32'h8000_0000) begin
         errors++;
         $display("FAIL divu_same_ops: got lo=%h hi=%h want 00000000/80000000", l, h);
      end
   endtask

   task automatic test_div_zero();
      int          cyc;
      logic [31:0] h, l;
      bus.signed_div = 1'b0;
      bus.a          = 32'd5;
      bus.b          = 32'd0;
      bus.start      = 1'b1;
      #1;
      checks++;
      if (bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL divz_stall_c0: got %b want 1", bus.stall);
      end
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.stall !== 1'b0 || bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5)
      begin
         errors++;
         $display("FAIL divz_c1: got done=%b stall=%b lo=%h hi=%h want 1/0/ffffffff/00000005",
                  bus.done, bus.stall, bus.lo, bus.hi);
      end
      bus.start = 1'b0;
      tick();
      run_op(1'b1, 32'hFFFF_FFF9, 32'd0, cyc, h, l);
      checks++;
      if (cyc != 1 || l !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFF9) begin
         errors++;
         $display("FAIL divz_signed: got cyc=%0d lo=%h hi=%h want 1/ffffffff/fffffff9", cyc, l, h);
      end
   endtask

   task automatic test_cancel();
      int          cyc;
      int          saw_done;
      logic [31:0] h, l;
      // previous results: lo=ffffffff hi=fffffff9 from the signed divide by zero
      saw_done       = 0;
      bus.signed_div = 1'b0;
      bus.a          = 32'd100;
      bus.b          = 32'd7;
      bus.start      = 1'b1;
      #1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (bus.done === 1'b1) saw_done++;
      end
      bus.cancel = 1'b1;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL cancel_stall_c10: got %b want 0", bus.stall);
      end
      tick();
      bus.cancel = 1'b0;
      bus.start  = 1'b0;
      #1;
      checks++;
      if (bus.stall !== 1'b0 || bus.done !== 1'b0 || saw_done != 0) begin
         errors++;
         $display("FAIL cancel_idle_c11: got stall=%b done=%b early_done=%0d want 0/0/0",
                  bus.stall, bus.done, saw_done);
      end
      checks++;
      if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'hFFFF_FFF9) begin
         errors++;
         $display("FAIL cancel_hold_hilo: got lo=%h hi=%h want ffffffff/fffffff9", bus.lo, bus.hi);
      end
      run_op(1'b0, 32'd100, 32'd7, cyc, h, l);
      checks++;
      if (cyc != 33 || l !== 32'd14 || h !== 32'd2) begin
         errors++;
         $display("FAIL cancel_restart: got cyc=%0d lo=%h hi=%h want 33/0000000e/00000002",
                  cyc, l, h);
      end
   endtask

   task automatic test_back_to_back();
      int          cyc;
      logic [31:0] h, l;
      run_op(1'b0, 32'hFFFF_FFFF, 32'h10, cyc, h, l);
      checks++;
      if (l !== 32'h0FFF_FFFF || h !== 32'hF) begin
         errors++;
         $display("FAIL b2b_first: got lo=%h hi=%h want 0fffffff/0000000f", l, h);
      end
      run_op(1'b0, 32'd1000, 32'd1000, cyc, h, l);
      checks++;
      if (cyc != 33 || l !== 32'd1 || h !== 32'd0) begin
         errors++;
         $display("FAIL b2b_second: got cyc=%0d lo=%h hi=%h want 33/00000001/00000000", cyc, l, h);
      end
   endtask

   task automatic test_mid_reset();
      int saw_done;
      saw_done       = 0;
      bus.signed_div = 1'b0;
      bus.a          = 32'd100;
      bus.b          = 32'd7;
      bus.start      = 1'b1;
      #1;
      for (int c = 0; c < 20; c++) tick();
      rst       = 1'b1;
      bus.start = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got hi=%h lo=%h done=%b stall=%b want 0/0/0/0",
                  bus.hi, bus.lo, bus.done, bus.stall);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.done === 1'b1) saw_done++;
      end
      checks++;
      if (saw_done != 0) begin
         errors++;
         $display("FAIL mid_reset_no_done: got %0d done pulses want 0", saw_done);
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.cancel     = 1'b0;
      test_reset();
      test_divu_basic();
      test_signed();
      test_overflow();
      test_div_zero();
      test_cancel();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
